// File: rtl/touch_event_ctrl.sv
// Touch interrupt front end: synchronises and debounces the active-low touch
// interrupt, then reads touch point 1 (XH, XL, YH, YL) one byte per request
// through the I2C read engine and presents 12-bit X/Y with a valid strobe.
//
// state      | meaning
// S_IDLE     | waiting for a falling edge on the synced interrupt
// S_DEBOUNCE | counting consecutive synced-low cycles
// S_REQ      | byte request outstanding at the I2C engine
// S_GAP      | one cycle with i2c_req low between byte requests
// S_DONE     | coordinates updated, touch_valid high for this cycle
module touch_event_ctrl #(
   parameter int         SYNC_STAGES     = 2,
   parameter int         DEBOUNCE_CYCLES = 16,
   parameter logic [7:0] REG_BASE        = 8'h03,
   parameter int         TIMEOUT_CYCLES  = 65535
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        en,
   input  logic        touch_int_n,
   output logic        i2c_req,
   output logic [7:0]  i2c_reg,
   input  logic        i2c_done,
   input  logic        i2c_err,
   input  logic [7:0]  i2c_rdata,
   input  logic        clr_flags,
   output logic        touch_valid,
   output logic [11:0] touch_x,
   output logic [11:0] touch_y,
   output logic [1:0]  touch_evt,
   output logic        busy,
   output logic        err_flag,
   output logic        ovr_flag
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
   // Timeout is a down-counter loaded on REQ entry; reaching zero ends the wait.
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_REQ,
      S_GAP,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   int_s;
   logic                   int_prev;
   logic                   int_fall;
   logic [DB_W-1:0]        db_cnt;
   logic [TO_W-1:0]        to_cnt;
   logic [1:0]             idx;
   // Only the bits that reach the outputs are kept; byte 3 is used straight
   // from i2c_rdata on the cycle it arrives.
   logic [1:0]             xh_evt;
   logic [3:0]             xh_lo;
   logic [7:0]             xl_byte;
   logic [3:0]             yh_lo;
   logic                   err_set;
   logic                   ovr_set;
   logic                   byte_ok;

   assign int_s    = sync_q[SYNC_STAGES-1];
   assign int_fall = int_prev & ~int_s;
   assign busy     = (state != S_IDLE);
   assign ovr_set  = int_fall & ((state == S_REQ) | (state == S_GAP) | (state == S_DONE));

   // Interrupt synchroniser and edge history; keeps running while disabled.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync_q   <= '1;
         int_prev <= 1'b1;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], touch_int_n};
         int_prev <= int_s;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the error and byte-capture qualifiers.
   always_comb begin
      state_next = state;
      err_set    = 1'b0;
      byte_ok    = 1'b0;
      case (state)
         S_IDLE: begin
            if (int_fall) state_next = S_DEBOUNCE;
         end
         S_DEBOUNCE: begin
            if (db_cnt == DB_LAST) state_next = S_REQ;
            else if (int_s)        state_next = S_IDLE;
         end
         S_REQ: begin
            if (i2c_done) begin
               if (i2c_err) begin
                  err_set    = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  byte_ok    = 1'b1;
                  state_next = (idx == 2'd3) ? S_DONE : S_GAP;
               end
            end else if (to_cnt == '0) begin
               err_set    = 1'b1;
               state_next = S_IDLE;
            end
         end
         S_GAP:   state_next = S_REQ;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (!en) begin
         state_next = S_IDLE;
         err_set    = 1'b0;
         byte_ok    = 1'b0;
      end
   end

   // Counters, byte buffer, registered request and coordinate outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         db_cnt      <= '0;
         to_cnt      <= '0;
         idx         <= '0;
         xh_evt      <= '0;
         xh_lo       <= '0;
         xl_byte     <= '0;
         yh_lo       <= '0;
         i2c_req     <= 1'b0;
         i2c_reg     <= '0;
         touch_valid <= 1'b0;
         touch_x     <= '0;
         touch_y     <= '0;
         touch_evt   <= '0;
      end else begin
         if (state == S_IDLE) begin
            db_cnt <= DB_ONE;
         end else if ((state == S_DEBOUNCE) && (state_next == S_DEBOUNCE)) begin
            db_cnt <= db_cnt + DB_ONE;
         end

         if (state != S_REQ) begin
            to_cnt <= TO_LOAD;
         end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TO_ONE;
         end

         if (state == S_IDLE) begin
            idx <= 2'd0;
         end else if (byte_ok) begin
            idx <= idx + 2'd1;
         end

         if (byte_ok) begin
            case (idx)
               2'd0: begin
                  xh_evt <= i2c_rdata[7:6];
                  xh_lo  <= i2c_rdata[3:0];
               end
               2'd1:    xl_byte <= i2c_rdata;
               2'd2:    yh_lo   <= i2c_rdata[3:0];
               default: ;
            endcase
         end

         // idx only advances on the way into GAP, so it already names the
         // byte about to be requested whenever REQ is next.
         i2c_req <= (state_next == S_REQ);
         if (state_next == S_REQ) begin
            i2c_reg <= REG_BASE + {6'b0, idx};
         end

         touch_valid <= (state_next == S_DONE);
         if (state_next == S_DONE) begin
            touch_x   <= {xh_lo, xl_byte};
            touch_y   <= {yh_lo, i2c_rdata};
            touch_evt <= xh_evt;
         end
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         err_flag <= 1'b0;
         ovr_flag <= 1'b0;
      end else begin
         err_flag <= err_set | (err_flag & ~clr_flags);
         ovr_flag <= ovr_set | (ovr_flag & ~clr_flags);
      end
   end

endmodule

// File: tb/tb_touch_event_ctrl.sv
// Bench for touch_event_ctrl: an I2C responder backed by a register map,
// a bus monitor, and directed plus randomized interrupt pulses checked
// against expectations derived from the register map and debounce rule.
module tb_touch_event_ctrl;

   localparam int DEB = 4;
   localparam int TO  = 20;

   logic        clk;
   logic        nrst;
   logic        en;
   logic        touch_int_n;
   logic        i2c_req;
   logic [7:0]  i2c_reg;
   logic        i2c_done;
   logic        i2c_err;
   logic [7:0]  i2c_rdata;
   logic        clr_flags;
   logic        touch_valid;
   logic [11:0] touch_x;
   logic [11:0] touch_y;
   logic [1:0]  touch_evt;
   logic        busy;
   logic        err_flag;
   logic        ovr_flag;

   touch_event_ctrl #(
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(DEB),
      .REG_BASE(8'h03),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .nrst(nrst),
      .en(en),
      .touch_int_n(touch_int_n),
      .i2c_req(i2c_req),
      .i2c_reg(i2c_reg),
      .i2c_done(i2c_done),
      .i2c_err(i2c_err),
      .i2c_rdata(i2c_rdata),
      .clr_flags(clr_flags),
      .touch_valid(touch_valid),
      .touch_x(touch_x),
      .touch_y(touch_y),
      .touch_evt(touch_evt),
      .busy(busy),
      .err_flag(err_flag),
      .ovr_flag(ovr_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Touch controller register map and responder behaviour knobs.
   logic [7:0] regmap [256];
   logic       hang_en = 1'b0;
   logic [7:0] hang_reg = 8'h00;
   logic       err_en = 1'b0;
   logic [7:0] err_reg = 8'h00;
   int         dly_min = 0;
   int         dly_max = 3;
   int         resp_dly;

   // Monitor state.
   int         cyc = 0;
   int         done_cyc = 0;
   logic [7:0] req_log [$];
   int         gap_log [$];
   int         req_hi = 0;
   int         low_run = 0;
   logic       req_prev = 1'b0;
   logic [7:0] reg_prev = 8'h00;
   logic       valid_prev = 1'b0;
   int         valid_cnt = 0;
   int         double_valid = 0;
   int         last_lat = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (i2c_done) done_cyc <= cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_int(input int len);
      touch_int_n = 1'b0;
      repeat (len) @(negedge clk);
      touch_int_n = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("idle_wait", busy, 1'b0);
   endtask

   task automatic wait_reqs(input int n, input int budget);
      int k;
      k = 0;
      while (req_log.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("req_wait", (req_log.size() >= n), 1'b1);
   endtask

   task automatic clear_logs();
      req_log.delete();
      gap_log.delete();
      req_hi = 0;
   endtask

   task automatic set_regs(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      regmap[8'h03] = b0;
      regmap[8'h04] = b1;
      regmap[8'h05] = b2;
      regmap[8'h06] = b3;
   endtask

   task automatic chk_coords(input string tag);
      chk({tag, "_x"},   touch_x,   {20'h0, regmap[8'h03][3:0], regmap[8'h04]});
      chk({tag, "_y"},   touch_y,   {20'h0, regmap[8'h05][3:0], regmap[8'h06]});
      chk({tag, "_evt"}, touch_evt, {30'h0, regmap[8'h03][7:6]});
   endtask

   // I2C engine model: answers each request after a random delay from the map.
   initial begin : responder
      i2c_done  = 1'b0;
      i2c_err   = 1'b0;
      i2c_rdata = 8'h00;
      resp_dly  = 0;
      forever begin
         @(negedge clk);
         if (i2c_done || !nrst || !i2c_req) begin
            i2c_done  = 1'b0;
            i2c_err   = 1'b0;
            i2c_rdata = 8'h00;
            resp_dly  = $urandom_range(dly_max, dly_min);
         end else if (!(hang_en && i2c_reg == hang_reg)) begin
            if (resp_dly > 0) begin
               resp_dly--;
            end else begin
               i2c_done  = 1'b1;
               i2c_err   = err_en && (i2c_reg == err_reg);
               i2c_rdata = regmap[i2c_reg];
            end
         end
      end
   end

   // Bus monitor: logs request addresses, low gaps and valid strobes.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!nrst) begin
            req_prev   = 1'b0;
            valid_prev = 1'b0;
            low_run    = 0;
         end else begin
            if (i2c_req) begin
               req_hi++;
               if (!req_prev) begin
                  req_log.push_back(i2c_reg);
                  gap_log.push_back(low_run);
               end else begin
                  chk("reg_stable", i2c_reg, reg_prev);
               end
               low_run = 0;
            end else begin
               low_run++;
            end
            if (touch_valid) begin
               valid_cnt++;
               last_lat = cyc - done_cyc;
               if (valid_prev) double_valid++;
            end
            req_prev   = i2c_req;
            reg_prev   = i2c_reg;
            valid_prev = touch_valid;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base;
      int len;
      logic [11:0] old_x;
      logic [11:0] old_y;
      logic [1:0]  old_evt;

      for (int i = 0; i < 256; i++) regmap[i] = 8'h00;
      nrst        = 1'b0;
      en          = 1'b1;
      touch_int_n = 1'b1;
      clr_flags   = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_req",   i2c_req,     1'b0);
      chk("rst_reg",   i2c_reg,     8'h00);
      chk("rst_valid", touch_valid, 1'b0);
      chk("rst_x",     touch_x,     12'h000);
      chk("rst_y",     touch_y,     12'h000);
      chk("rst_evt",   touch_evt,   2'b00);
      chk("rst_busy",  busy,        1'b0);
      chk("rst_err",   err_flag,    1'b0);
      chk("rst_ovr",   ovr_flag,    1'b0);

      nrst = 1'b1;
      repeat (3) @(negedge clk);

      // Short glitch is rejected.
      clear_logs();
      base = valid_cnt;
      pulse_int(2);
      repeat (20) @(negedge clk);
      chk("glitch_reqs",  req_log.size(), 0);
      chk("glitch_valid", valid_cnt - base, 0);
      chk("glitch_busy",  busy, 1'b0);
      chk("glitch_err",   err_flag, 1'b0);
      chk("glitch_ovr",   ovr_flag, 1'b0);

      // Directed read: held low for 10 cycles, fixed register contents.
      set_regs(8'h42, 8'h7F, 8'h01, 8'hE0);
      clear_logs();
      base = valid_cnt;
      touch_int_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("edge_lat_early", busy, 1'b0);
      @(negedge clk);
      chk("edge_lat", busy, 1'b1);
      repeat (7) @(negedge clk);
      touch_int_n = 1'b1;
      wait_idle(200);
      chk("dir_nreq", req_log.size(), 4);
      for (int k = 0; k < 4 && k < req_log.size(); k++)
         chk("dir_reg", req_log[k], 8'h03 + k);
      for (int k = 1; k < 4 && k < gap_log.size(); k++)
         chk("dir_gap", gap_log[k], 1);
      chk("dir_valid", valid_cnt - base, 1);
      chk("dir_x",   touch_x,   12'h27F);
      chk("dir_y",   touch_y,   12'h1E0);
      chk("dir_evt", touch_evt, 2'b01);
      chk("dir_lat", last_lat,  1);
      chk("dir_flags", {err_flag, ovr_flag}, 2'b00);
      repeat (4) @(negedge clk);

      // Randomized pulse lengths and register contents.
      for (int it = 0; it < 8; it++) begin
         len = $urandom_range(2 * DEB, 1);
         set_regs($urandom, $urandom, $urandom, $urandom);
         old_x = touch_x;
         old_y = touch_y;
         clear_logs();
         base = valid_cnt;
         pulse_int(len);
         wait_idle(300);
         if (len >= DEB) begin
            chk("rnd_valid", valid_cnt - base, 1);
            chk("rnd_nreq", req_log.size(), 4);
            chk_coords("rnd");
            chk("rnd_lat", last_lat, 1);
         end else begin
            chk("rnd_rej_valid", valid_cnt - base, 0);
            chk("rnd_rej_nreq", req_log.size(), 0);
            chk("rnd_rej_x", touch_x, old_x);
            chk("rnd_rej_y", touch_y, old_y);
         end
         repeat (5) @(negedge clk);
      end

      // NACK on the second byte.
      set_regs($urandom, $urandom, $urandom, $urandom);
      old_x = touch_x;
      old_y = touch_y;
      err_en  = 1'b1;
      err_reg = 8'h04;
      clear_logs();
      base = valid_cnt;
      pulse_int(5);
      wait_idle(200);
      chk("nack_err",   err_flag, 1'b1);
      chk("nack_valid", valid_cnt - base, 0);
      chk("nack_nreq",  req_log.size(), 2);
      chk("nack_x",     touch_x, old_x);
      chk("nack_y",     touch_y, old_y);
      err_en = 1'b0;
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      chk("nack_clr", err_flag, 1'b0);
      repeat (4) @(negedge clk);

      // Engine never answers: request times out.
      hang_en  = 1'b1;
      hang_reg = 8'h03;
      clear_logs();
      pulse_int(5);
      wait_idle(100);
      chk("to_cycles", req_hi, TO);
      chk("to_err",    err_flag, 1'b1);
      chk("to_req",    i2c_req, 1'b0);
      chk("to_busy",   busy, 1'b0);
      hang_en = 1'b0;
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      chk("to_clr", err_flag, 1'b0);
      repeat (4) @(negedge clk);

      // Second falling edge during a read: flagged, not queued.
      dly_min = 4;
      dly_max = 4;
      set_regs($urandom, $urandom, $urandom, $urandom);
      clear_logs();
      base = valid_cnt;
      pulse_int(5);
      wait_reqs(2, 100);
      pulse_int(6);
      wait_idle(200);
      chk("ovr_flag",  ovr_flag, 1'b1);
      chk("ovr_valid", valid_cnt - base, 1);
      chk_coords("ovr");
      repeat (30) @(negedge clk);
      chk("ovr_nreq", req_log.size(), 4);
      chk("ovr_busy", busy, 1'b0);
      dly_min = 0;
      dly_max = 3;
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      chk("ovr_clr", ovr_flag, 1'b0);
      repeat (4) @(negedge clk);

      // Reset while waiting on byte 2.
      set_regs($urandom, $urandom, $urandom, $urandom);
      hang_en  = 1'b1;
      hang_reg = 8'h04;
      clear_logs();
      pulse_int(5);
      wait_reqs(2, 100);
      repeat (2) @(negedge clk);
      nrst = 1'b0;
      #1;
      chk("mrst_req",   i2c_req,     1'b0);
      chk("mrst_reg",   i2c_reg,     8'h00);
      chk("mrst_valid", touch_valid, 1'b0);
      chk("mrst_x",     touch_x,     12'h000);
      chk("mrst_y",     touch_y,     12'h000);
      chk("mrst_evt",   touch_evt,   2'b00);
      chk("mrst_busy",  busy,        1'b0);
      @(negedge clk);
      nrst    = 1'b1;
      hang_en = 1'b0;
      repeat (4) @(negedge clk);

      // Full read to load coordinates, then disable in the middle of the next.
      set_regs($urandom, $urandom, $urandom, $urandom);
      clear_logs();
      pulse_int(5);
      wait_idle(200);
      chk_coords("pre_en");
      old_x   = touch_x;
      old_y   = touch_y;
      old_evt = touch_evt;
      repeat (4) @(negedge clk);
      set_regs($urandom, $urandom, $urandom, $urandom);
      hang_en  = 1'b1;
      hang_reg = 8'h05;
      clear_logs();
      base = valid_cnt;
      pulse_int(5);
      wait_reqs(3, 100);
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("en_busy", busy, 1'b0);
      chk("en_req",  i2c_req, 1'b0);
      chk("en_x",    touch_x, old_x);
      chk("en_y",    touch_y, old_y);
      chk("en_evt",  touch_evt, old_evt);
      en = 1'b1;
      hang_en = 1'b0;
      repeat (30) @(negedge clk);
      chk("en_valid", valid_cnt - base, 0);
      chk("en_nreq",  req_log.size(), 3);
      chk("en_idle",  busy, 1'b0);

      chk("valid_width", double_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
